// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer
//   Control FSM for the snake datapath. Counts completed video frames and,
//   every FRAMES_PER_TICK frames, runs a fixed sequence of one-cycle enables:
//   latch direction, move head, evaluate collisions, grow or shift tails,
//   then place a new apple when one was eaten. All datapath updates are
//   single-clock enables on clk.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-low reset
//   frame_end      one-cycle pulse at the last pixel of a frame
//   pause          holds the frame counter while idle
//   direction      requested direction: 00 left, 01 top, 10 right, 11 down
//   tail_count     current tail count from the datapath
//   head_hit_apple head on apple (sampled in EVAL)
//   head_hit_tail  head on a live tail (sampled in EVAL)
//   cell_occupied  (spawn_x,spawn_y) is head or live tail (sampled while spawning)
//   dir_latched    direction used by the current move
//   move_stb       advance head one cell along dir_latched
//   grow_stb       append a tail at the previous head position
//   shift_stb      shift tails without growth
//   spawn_stb      load spawn_x/spawn_y as the new apple
//   spawn_x/y      apple candidate / committed cell
//   busy           update sequence in progress
//   game_over      sticky, self-collision
//   game_won       sticky, MAX_TAILS reached
module game_tick_sequencer #(
  parameter int FRAMES_PER_TICK = 8,
  parameter int GRID_W          = 40,
  parameter int GRID_H          = 30,
  parameter int XW              = 6,
  parameter int YW              = 5,
  parameter int TW              = 5,
  parameter int MAX_TAILS       = 16,
  parameter int SPAWN_RETRIES   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_end,
  input  logic          pause,
  input  logic [1:0]    direction,
  input  logic [TW-1:0] tail_count,
  input  logic          head_hit_apple,
  input  logic          head_hit_tail,
  input  logic          cell_occupied,
  output logic [1:0]    dir_latched,
  output logic          move_stb,
  output logic          grow_stb,
  output logic          shift_stb,
  output logic          spawn_stb,
  output logic [XW-1:0] spawn_x,
  output logic [YW-1:0] spawn_y,
  output logic          busy,
  output logic          game_over,
  output logic          game_won
);

  localparam int FCW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int RCW = $clog2(SPAWN_RETRIES + 1);

  localparam logic [FCW-1:0] FRAME_LAST  = FCW'(FRAMES_PER_TICK - 1);
  localparam logic [RCW-1:0] RETRY_MAX   = RCW'(SPAWN_RETRIES);
  localparam logic [XW-1:0]  GRID_W_X    = XW'(GRID_W);
  localparam logic [YW-1:0]  GRID_H_Y    = YW'(GRID_H);
  localparam logic [XW-1:0]  X_LAST      = XW'(GRID_W - 1);
  localparam logic [YW-1:0]  Y_LAST      = YW'(GRID_H - 1);
  localparam logic [TW:0]    MAX_TAILS_T = (TW+1)'(MAX_TAILS);
  localparam logic [XW-1:0]  SPAWN_X_RST = XW'(34);
  localparam logic [YW-1:0]  SPAWN_Y_RST = YW'(9);
  localparam logic [15:0]    LFSR_SEED   = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LATCH       = 3'd1,
    ST_MOVE        = 3'd2,
    ST_EVAL        = 3'd3,
    ST_SPAWN_TRY   = 3'd4,
    ST_SPAWN_CHECK = 3'd5,
    ST_SCAN        = 3'd6,
    ST_OVER        = 3'd7
  } state_t;

  state_t         state_r;
  logic [FCW-1:0] frame_cnt_r;
  logic [RCW-1:0] retry_r;
  logic [15:0]    lfsr_r;
  logic [1:0]     dir_latched_r;
  logic [XW-1:0]  spawn_x_r;
  logic [YW-1:0]  spawn_y_r;
  logic           move_stb_r;
  logic           busy_r;
  logic           game_over_r;
  logic           game_won_r;

  logic           lfsr_fb_s;
  logic           grow_s;
  logic           shift_s;
  logic           spawn_s;
  logic [RCW-1:0] retry_next_s;
  logic [TW:0]    tail_inc_s;
  logic           reversal_s;
  logic [XW-1:0]  scan_x_s;
  logic [YW-1:0]  scan_y_s;

  // Fold a raw random column into the grid; two subtractions cover 0..2*GRID_W+GRID_W-1.
  function automatic logic [XW-1:0] fold_x(input logic [XW-1:0] v);
    logic [XW-1:0] t;
    t = v;
    t = (t >= GRID_W_X) ? (t - GRID_W_X) : t;
    t = (t >= GRID_W_X) ? (t - GRID_W_X) : t;
    return t;
  endfunction

  // Fold a raw random row into the grid.
  function automatic logic [YW-1:0] fold_y(input logic [YW-1:0] v);
    logic [YW-1:0] t;
    t = v;
    t = (t >= GRID_H_Y) ? (t - GRID_H_Y) : t;
    t = (t >= GRID_H_Y) ? (t - GRID_H_Y) : t;
    return t;
  endfunction

  // Free-running Fibonacci LFSR, taps 16,14,13,11; the nonzero seed keeps it off zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end

  // Helper terms: LFSR feedback, retry increment, win test, reversal test, row-major scan step.
  always_comb begin
    lfsr_fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    retry_next_s = retry_r + RCW'(1);
    tail_inc_s   = {1'b0, tail_count} + {{TW{1'b0}}, 1'b1};
    reversal_s   = (tail_count != {TW{1'b0}}) && (direction == (dir_latched_r ^ 2'b10));
    if (spawn_x_r == X_LAST) begin
      scan_x_s = {XW{1'b0}};
      scan_y_s = (spawn_y_r == Y_LAST) ? {YW{1'b0}} : (spawn_y_r + YW'(1));
    end else begin
      scan_x_s = spawn_x_r + XW'(1);
      scan_y_s = spawn_y_r;
    end
  end

  // Strobes that depend on datapath status valid only in the current state cycle.
  always_comb begin
    grow_s  = 1'b0;
    shift_s = 1'b0;
    spawn_s = 1'b0;
    case (state_r)
      ST_EVAL: begin
        if (head_hit_tail) begin
          grow_s = 1'b0;
        end else if (head_hit_apple) begin
          grow_s = 1'b1;
        end else begin
          shift_s = 1'b1;
        end
      end
      ST_SPAWN_CHECK, ST_SCAN: begin
        spawn_s = ~cell_occupied;
      end
      default: begin
        spawn_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered direction, coordinates, move strobe and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      frame_cnt_r   <= {FCW{1'b0}};
      retry_r       <= {RCW{1'b0}};
      dir_latched_r <= 2'b10;
      spawn_x_r     <= SPAWN_X_RST;
      spawn_y_r     <= SPAWN_Y_RST;
      move_stb_r    <= 1'b0;
      busy_r        <= 1'b0;
      game_over_r   <= 1'b0;
      game_won_r    <= 1'b0;
    end else begin
      move_stb_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (frame_end && !pause) begin
            if (frame_cnt_r == FRAME_LAST) begin
              frame_cnt_r <= {FCW{1'b0}};
              state_r     <= ST_LATCH;
              busy_r      <= 1'b1;
            end else begin
              frame_cnt_r <= frame_cnt_r + FCW'(1);
            end
          end else begin
            frame_cnt_r <= frame_cnt_r;
          end
        end
        ST_LATCH: begin
          // A reversal onto the body is ignored once the snake has tails.
          if (!reversal_s) begin
            dir_latched_r <= direction;
          end else begin
            dir_latched_r <= dir_latched_r;
          end
          state_r    <= ST_MOVE;
          move_stb_r <= 1'b1;
        end
        ST_MOVE: begin
          state_r <= ST_EVAL;
        end
        ST_EVAL: begin
          if (head_hit_tail) begin
            game_over_r <= 1'b1;
            state_r     <= ST_OVER;
            busy_r      <= 1'b0;
          end else if (head_hit_apple) begin
            if (tail_inc_s == MAX_TAILS_T) begin
              game_won_r <= 1'b1;
              state_r    <= ST_OVER;
              busy_r     <= 1'b0;
            end else begin
              retry_r <= {RCW{1'b0}};
              state_r <= ST_SPAWN_TRY;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_SPAWN_TRY: begin
          spawn_x_r <= fold_x(lfsr_r[XW-1:0]);
          spawn_y_r <= fold_y(lfsr_r[15:16-YW]);
          state_r   <= ST_SPAWN_CHECK;
        end
        ST_SPAWN_CHECK: begin
          if (!cell_occupied) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (retry_next_s == RETRY_MAX) begin
            // Random attempts exhausted: step to the next cell and scan from there.
            retry_r   <= retry_next_s;
            spawn_x_r <= scan_x_s;
            spawn_y_r <= scan_y_s;
            state_r   <= ST_SCAN;
          end else begin
            retry_r <= retry_next_s;
            state_r <= ST_SPAWN_TRY;
          end
        end
        ST_SCAN: begin
          if (!cell_occupied) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            spawn_x_r <= scan_x_s;
            spawn_y_r <= scan_y_s;
          end
        end
        ST_OVER: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dir_latched = dir_latched_r;
  assign move_stb    = move_stb_r;
  assign grow_stb    = grow_s;
  assign shift_stb   = shift_s;
  assign spawn_stb   = spawn_s;
  assign spawn_x     = spawn_x_r;
  assign spawn_y     = spawn_y_r;
  assign busy        = busy_r;
  assign game_over   = game_over_r;
  assign game_won    = game_won_r;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Testbench for game_tick_sequencer (FRAMES_PER_TICK=3). Expected strobe
// events are queued when a tick is launched and compared each cycle as the
// DUT produces strobes.
module tb_game_tick_sequencer;

  localparam int FPT = 3;
  localparam int XW  = 6;
  localparam int YW  = 5;
  localparam int TW  = 5;

  localparam logic [3:0] K_MOVE  = 4'b0001;
  localparam logic [3:0] K_GROW  = 4'b0010;
  localparam logic [3:0] K_SHIFT = 4'b0100;
  localparam logic [3:0] K_SPAWN = 4'b1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_end;
  logic          pause;
  logic [1:0]    direction;
  logic [TW-1:0] tail_count;
  logic          head_hit_apple;
  logic          head_hit_tail;
  logic          cell_occupied;
  logic [1:0]    dir_latched;
  logic          move_stb;
  logic          grow_stb;
  logic          shift_stb;
  logic          spawn_stb;
  logic [XW-1:0] spawn_x;
  logic [YW-1:0] spawn_y;
  logic          busy;
  logic          game_over;
  logic          game_won;

  typedef struct packed {
    int         cyc;
    logic [3:0] kind;
  } exp_t;

  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   occ_last = -1;

  game_tick_sequencer #(
    .FRAMES_PER_TICK(FPT),
    .GRID_W(40),
    .GRID_H(30),
    .XW(XW),
    .YW(YW),
    .TW(TW),
    .MAX_TAILS(16),
    .SPAWN_RETRIES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_end(frame_end),
    .pause(pause),
    .direction(direction),
    .tail_count(tail_count),
    .head_hit_apple(head_hit_apple),
    .head_hit_tail(head_hit_tail),
    .cell_occupied(cell_occupied),
    .dir_latched(dir_latched),
    .move_stb(move_stb),
    .grow_stb(grow_stb),
    .shift_stb(shift_stb),
    .spawn_stb(spawn_stb),
    .spawn_x(spawn_x),
    .spawn_y(spawn_y),
    .busy(busy),
    .game_over(game_over),
    .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int c, input logic [3:0] k);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, drive cell_occupied for it, then score any strobe.
  task automatic step();
    logic [3:0] kind;
    exp_t       e;
    @(posedge clk);
    #1;
    cyc++;
    cell_occupied = (cyc <= occ_last);
    #1;
    kind = {spawn_stb, shift_stb, grow_stb, move_stb};
    if (kind != 4'b0000 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe: cycle %0d got %b, want no strobe", cyc, kind);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.kind !== kind) begin
          bad++;
          $display("FAIL strobe: cycle %0d got %b, want %b at cycle %0d", cyc, kind, e.kind, e.cyc);
        end
      end
    end
  endtask

  task automatic frame_pulse(output int n);
    n = cyc;
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  // Three frames with a gap; n is the cycle of the frame that launches the tick.
  task automatic do_tick(output int n);
    int d;
    frame_pulse(d);
    step();
    frame_pulse(d);
    step();
    frame_pulse(n);
  endtask

  task automatic advance(input int x, input int y, output int nx, output int ny);
    if (x == 39) begin
      nx = 0;
      ny = (y == 29) ? 0 : y + 1;
    end else begin
      nx = x + 1;
      ny = y;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_end = 1'b0; pause = 1'b0; direction = 2'b10;
    tail_count = '0; head_hit_apple = 1'b0; head_hit_tail = 1'b0;
    step();
    step();
    total++; if (dir_latched !== 2'b10) begin bad++; $display("FAIL reset_dir: got %b want 10", dir_latched); end
    total++; if (spawn_x !== 6'd34) begin bad++; $display("FAIL reset_spawn_x: got %0d want 34", spawn_x); end
    total++; if (spawn_y !== 5'd9) begin bad++; $display("FAIL reset_spawn_y: got %0d want 9", spawn_y); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({game_over, game_won} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {game_over, game_won}); end
    total++; if ({spawn_stb, shift_stb, grow_stb, move_stb} !== 4'b0000) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {spawn_stb, shift_stb, grow_stb, move_stb}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_tick();
    int n;
    direction = 2'b10;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_SHIFT);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tick_busy: cycle %0d got %b want 1", cyc, busy); end
    for (int i = 2; i <= 4; i++) begin
      step();
      total++;
      if (busy !== (i <= 3)) begin bad++; $display("FAIL tick_busy: cycle %0d got %b want %b", cyc, busy, (i <= 3)); end
    end
    step();
    total++; if (dir_latched !== 2'b10) begin bad++; $display("FAIL tick_dir: got %b want 10", dir_latched); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tick_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_direction();
    int n;
    tail_count = 5'd2; direction = 2'b00;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_SHIFT);
    repeat (4) step();
    total++; if (dir_latched !== 2'b10) begin bad++; $display("FAIL dir_reversal: got %b want 10", dir_latched); end
    tail_count = 5'd0;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_SHIFT);
    repeat (4) step();
    total++; if (dir_latched !== 2'b00) begin bad++; $display("FAIL dir_no_tail: got %b want 00", dir_latched); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dir_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    direction = 2'b00; tail_count = 5'd0;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    step();
    total++; if (move_stb !== 1'b1) begin bad++; $display("FAIL mid_move: got %b want 1", move_stb); end
    reset = 1'b0;
    #1;
    total++; if (move_stb !== 1'b0) begin bad++; $display("FAIL mid_move_drop: got %b want 0", move_stb); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (dir_latched !== 2'b10) begin bad++; $display("FAIL mid_dir: got %b want 10", dir_latched); end
    total++; if ({spawn_x, spawn_y} !== {6'd34, 5'd9}) begin bad++; $display("FAIL mid_spawn: got %0d,%0d want 34,9", spawn_x, spawn_y); end
    step();
    reset = 1'b1;
    step();
    direction = 2'b10;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_SHIFT);
    repeat (4) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_apple_spawn();
    int n;
    tail_count = 5'd4; head_hit_apple = 1'b1; occ_last = -1;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_GROW);
    push_exp(n + 5, K_SPAWN);
    repeat (4) step();
    total++; if (spawn_x >= 6'd40) begin bad++; $display("FAIL spawn_x_range: got %0d want <40", spawn_x); end
    total++; if (spawn_y >= 5'd30) begin bad++; $display("FAIL spawn_y_range: got %0d want <30", spawn_y); end
    head_hit_apple = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spawn_busy: got %b want 0", busy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL spawn_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_scan();
    int n;
    int ex;
    int ey;
    tail_count = 5'd4; head_hit_apple = 1'b1;
    do_tick(n);
    occ_last = n + 19;
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_GROW);
    push_exp(n + 20, K_SPAWN);
    while (cyc < n + 19) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy: got %b want 1", busy); end
    advance(int'(spawn_x), int'(spawn_y), ex, ey);
    step();
    total++; if (int'(spawn_x) != ex || int'(spawn_y) != ey) begin bad++; $display("FAIL scan_cell: got %0d,%0d want %0d,%0d", spawn_x, spawn_y, ex, ey); end
    total++; if (spawn_x >= 6'd40 || spawn_y >= 5'd30) begin bad++; $display("FAIL scan_range: got %0d,%0d want <40,<30", spawn_x, spawn_y); end
    occ_last = -1; head_hit_apple = 1'b0;
    repeat (2) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scan_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_pause();
    int n;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_pulse(n);
      step();
    end
    repeat (4) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_busy: got %b want 0", busy); end
    pause = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pause_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_game_over();
    int n;
    tail_count = 5'd4; head_hit_tail = 1'b1; head_hit_apple = 1'b1;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    repeat (3) step();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_flag: got %b want 1", game_over); end
    total++; if (game_won !== 1'b0) begin bad++; $display("FAIL over_won: got %b want 0", game_won); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL over_busy: got %b want 0", busy); end
    head_hit_tail = 1'b0; head_hit_apple = 1'b0;
    for (int i = 0; i < 6; i++) begin
      frame_pulse(n);
      step();
    end
    repeat (4) step();
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_sticky: got %b want 1", game_over); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL over_pending: got %0d want 0", exp_q.size()); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL over_clear: got %b want 0", game_over); end
  endtask

  task automatic test_game_won();
    int n;
    tail_count = 5'd15; head_hit_apple = 1'b1; head_hit_tail = 1'b0; occ_last = -1;
    do_tick(n);
    push_exp(n + 2, K_MOVE);
    push_exp(n + 3, K_GROW);
    repeat (3) step();
    total++; if (game_won !== 1'b1) begin bad++; $display("FAIL won_flag: got %b want 1", game_won); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL won_over: got %b want 0", game_over); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL won_busy: got %b want 0", busy); end
    repeat (5) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL won_pending: got %0d want 0", exp_q.size()); end
    head_hit_apple = 1'b0;
  endtask

  initial begin
    cell_occupied = 1'b0;
    test_reset();
    test_tick();
    test_direction();
    test_reset_mid();
    test_apple_spawn();
    test_scan();
    test_pause();
    test_game_over();
    test_game_won();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_tick_sequencer.md
Name: game_tick_sequencer

Overview:
Control FSM that sequences game state updates for the snake datapath. It counts completed video frames and issues one update tick every FRAMES_PER_TICK frames. Each tick runs a fixed ordered sequence of one-cycle strobes to the datapath: latch direction, move head, evaluate collisions, grow or shift tails, spawn apple. It replaces ad-hoc derived-clock update logic, so all datapath updates are single-clock enables on clk.

Parameters:
FRAMES_PER_TICK, 8, frames between update ticks (>=1)
GRID_W, 40, grid columns
GRID_H, 30, grid rows
XW, 6, column coordinate width
YW, 5, row coordinate width
TW, 5, tail counter width
MAX_TAILS, 16, tail count at which game is won
SPAWN_RETRIES, 8, random apple attempts before linear-scan fallback

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_end  in  1  one-cycle pulse at last pixel of frame
pause  in  1  holds frame counter while in IDLE
direction  in  2  requested direction: 00 left, 01 top, 10 right, 11 down
tail_count  in  TW  current tail count from datapath
head_hit_apple  in  1  head on apple; valid in EVAL
head_hit_tail  in  1  head on any live tail; valid in EVAL
cell_occupied  in  1  (spawn_x,spawn_y) is head or live tail; combinational, valid in SPAWN_CHECK
dir_latched  out  2  direction used by current move
move_stb  out  1  advance head one cell along dir_latched
grow_stb  out  1  append tail at previous head position
shift_stb  out  1  shift tails, no growth
spawn_stb  out  1  load spawn_x/spawn_y as new apple
spawn_x  out  XW  apple candidate / committed column
spawn_y  out  YW  apple candidate / committed row
busy  out  1  sequence in progress
game_over  out  1  sticky, self-collision
game_won  out  1  sticky, MAX_TAILS reached

Behaviour:
- Reset (reset=0, async): state IDLE, frame count 0, retry count 0, all strobes 0, busy 0, game_over 0, game_won 0, dir_latched 10, spawn_x 34, spawn_y 9, LFSR 16'hACE1. Strobes drop immediately on reset assertion, including mid-sequence.
- 16-bit Fibonacci LFSR, taps 16,14,13,11. Runs free every clk. Never reaches zero.
- States: IDLE, LATCH, MOVE, EVAL, SPAWN_TRY, SPAWN_CHECK, SCAN, OVER.
- IDLE: on frame_end with pause=0, increment frame count. If count==FRAMES_PER_TICK-1 on that pulse, clear count and go to LATCH. frame_end with pause=1 does not count. frame_end outside IDLE is ignored and not counted.
- LATCH (1 cycle):
  - dir_latched <= direction, unless tail_count!=0 and direction==dir_latched^2'b10 (reversal); on reversal, keep dir_latched.
  - Go to MOVE.
- MOVE (1 cycle): move_stb=1. Go to EVAL. Cycle count: frame_end (tick) at cycle N, LATCH at N+1, move_stb at N+2.
- EVAL (1 cycle), priority order:
  1. head_hit_tail=1: set game_over, go to OVER. No grow or shift.
  2. Else head_hit_apple=1: grow_stb=1. If tail_count+1==MAX_TAILS, set game_won and go to OVER. Otherwise clear retry count and go to SPAWN_TRY.
  3. Else: shift_stb=1, go to IDLE.
- SPAWN_TRY (1 cycle):
  - spawn_x <= LFSR[XW-1:0], minus GRID_W if >=GRID_W; repeat the subtract once more if still >=GRID_W.
  - spawn_y <= LFSR[15:16-YW], same reduction with GRID_H.
  - Go to SPAWN_CHECK.
- SPAWN_CHECK (1 cycle):
  - cell_occupied=0: spawn_stb=1, go to IDLE.
  - Else increment retry count. If retry count now ==SPAWN_RETRIES, go to SCAN; else go to SPAWN_TRY.
- SCAN: each cycle advance (spawn_x,spawn_y) row-major. x wraps GRID_W-1->0 and increments y; (GRID_W-1,GRID_H-1) wraps to (0,0). Next cycle, test cell_occupied as in SPAWN_CHECK; the first free cell gets spawn_stb and the FSM returns to IDLE. Termination is guaranteed because MAX_TAILS+1 < GRID_W*GRID_H.
- OVER: terminal; all strobes 0, busy 0, flags held until reset.
- Strobes are mutually exclusive and one cycle wide. busy=1 in every state except IDLE and OVER.
- pause asserted outside IDLE has no effect on the current sequence.

Test Plan:
- FRAMES_PER_TICK=3, direction=10, no hits; pulse frame_end x3 -> move_stb exactly 2 cycles after 3rd pulse, shift_stb 1 cycle later, busy high 3 cycles.
- dir_latched=10, tail_count=2, direction=00 at tick -> dir_latched stays 10; repeat with tail_count=0 -> dir_latched becomes 00.
- head_hit_apple=1 in EVAL, tail_count=4, cell_occupied=0 -> grow_stb, then spawn_stb 2 cycles later with spawn_x<40, spawn_y<30.
- head_hit_apple=1, cell_occupied forced 1 for 8 checks, then 0 -> exactly 8 random tries, SCAN entered, spawn_stb at first cell with cell_occupied=0, coordinates in range.
- head_hit_tail=1 and head_hit_apple=1 together -> game_over=1, no grow_stb/shift_stb; later frame_end pulses produce no strobes; tail_count=15 with apple hit -> grow_stb, game_won=1.
- pause=1 during 5 frame_end pulses -> no tick. Assert reset low in MOVE -> move_stb drops asynchronously, all outputs at reset values, then a tick occurs again after FRAMES_PER_TICK frames.
